// File: rtl/exu_arbiter.sv
// exu_arbiter: round-robin share of one combinational EXU between the
// decode/ALU port (0) and the branch-compare port (1). One op in flight:
// accept -> hold operands EXU_LAT cycles -> capture result -> respond.
module exu_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int EXU_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATAWIDTH-1:0] req0_src1,
    input  logic [DATAWIDTH-1:0] req0_src2,
    input  logic [DATAWIDTH-1:0] req0_imm,
    input  logic [3:0]           req0_mode,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATAWIDTH-1:0] req1_src1,
    input  logic [DATAWIDTH-1:0] req1_src2,
    input  logic [DATAWIDTH-1:0] req1_imm,
    input  logic [3:0]           req1_mode,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic [DATAWIDTH-1:0] exu_src1,
    output logic [DATAWIDTH-1:0] exu_src2,
    output logic [DATAWIDTH-1:0] exu_imm,
    output logic [3:0]           exu_mode,
    input  logic [DATAWIDTH-1:0] exu_data,
    output logic                 busy,
    output logic                 grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic [DATAWIDTH-1:0] src1;
        logic [DATAWIDTH-1:0] src2;
        logic [DATAWIDTH-1:0] imm;
        logic [3:0]           mode;
    } op_t;

    // Counter preload: ISSUE lasts lat_cnt+1 cycles, so EXU_LAT cycles total.
    localparam logic [3:0] LAT_LOAD = 4'(EXU_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] lat_cnt, lat_cnt_nxt;
    logic       last_grant;
    logic       win;
    logic       accept;
    logic       capture;
    op_t        op_q;
    op_t [1:0]  req_op;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;

    assign req_op[0] = {req0_src1, req0_src2, req0_imm, req0_mode};
    assign req_op[1] = {req1_src1, req1_src2, req1_imm, req1_mode};
    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Single requester wins outright; on a tie the port that did not go last wins.
    assign win = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    // Next-state, handshakes and counter update.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        accept      = 1'b0;
        capture     = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[win] = 1'b1;
                    accept         = 1'b1;
                    lat_cnt_nxt    = LAT_LOAD;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    lat_cnt_nxt = lat_cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid[grant_id] = 1'b1;
                if (rsp_ready[grant_id]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // Operand latch on accept, result capture at the end of settle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            rsp_data   <= '0;
        end else begin
            if (accept) begin
                op_q       <= req_op[win];
                grant_id   <= win;
                last_grant <= win;
            end
            if (capture) rsp_data <= exu_data;
        end
    end

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign exu_src1   = op_q.src1;
    assign exu_src2   = op_q.src2;
    assign exu_imm    = op_q.imm;
    assign exu_mode   = op_q.mode;
    assign busy       = (state != IDLE);

endmodule
